// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with registered read data, occupancy level and almost-flags.
// Optional macro SYNC_FIFO_ERR_EN adds err_clr plus sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         data_1_en,
  input  logic [WIDTH-1:0]             data_1,
  input  logic                         data_2_rd,
  output logic [WIDTH-1:0]             data_2,
  output logic                         data_2_valid,
  output logic                         buffer_empty,
  output logic                         buffer_full,
  output logic                         almost_empty,
  output logic                         almost_full,
`ifdef SYNC_FIFO_ERR_EN
  input  logic                         err_clr,
  output logic                         overflow,
  output logic                         underflow,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] L_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] L_AF   = LW'(AF_LEVEL);
  localparam logic [LW-1:0] L_AE   = LW'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_data_2;
  logic             r_valid;
  logic             w_rd_ok, w_wr_ok;

  assign w_rd_ok      = data_2_rd & ~buffer_empty;
  assign w_wr_ok      = data_1_en & (~buffer_full | w_rd_ok);
  assign buffer_empty = r_level == '0;
  assign buffer_full  = r_level == L_FULL;
  assign almost_empty = r_level <= L_AE;
  assign almost_full  = r_level >= L_AF;
  assign level        = r_level;
  assign data_2       = r_data_2;
  assign data_2_valid = r_valid;

  // storage array: not reset, written only on an accepted write
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wptr] <= data_1;
  end

  // pointers, occupancy and registered read port; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_data_2 <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + PW'(1);
      if (w_rd_ok) r_rptr <= r_rptr + PW'(1);
      if (w_rd_ok) r_data_2 <= r_mem[r_rptr];
      r_valid <= w_rd_ok;
      r_level <= (w_wr_ok & ~w_rd_ok) ? r_level + LW'(1) :
                 (w_rd_ok & ~w_wr_ok) ? r_level - LW'(1) : r_level;
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic r_overflow, r_underflow;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

  // sticky error flags; a new error in the same cycle wins over err_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (data_1_en & ~w_wr_ok) | (r_overflow & ~err_clr);
      r_underflow <= (data_2_rd & buffer_empty) | (r_underflow & ~err_clr);
    end
  end
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: table-driven directed checks of sync_fifo_param plus wrap and async-reset sequences.
module tb_sync_fifo_param;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_1_en;
  logic [15:0] data_1;
  logic        data_2_rd;
  logic [15:0] data_2;
  logic        data_2_valid, buffer_empty, buffer_full, almost_empty, almost_full;
  logic [3:0]  level;
`ifdef SYNC_FIFO_ERR_EN
  logic        err_clr, overflow, underflow;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        wr;
    logic [15:0] wd;
    logic        rd;
    logic [15:0] d2;
    logic        v;
    int          lvl;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t        tv [22];
  logic [15:0] q [$];
  logic [15:0] exp_d;

  sync_fifo_param #(.WIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .data_1_en(data_1_en), .data_1(data_1), .data_2_rd(data_2_rd),
    .data_2(data_2), .data_2_valid(data_2_valid), .buffer_empty(buffer_empty),
    .buffer_full(buffer_full), .almost_empty(almost_empty), .almost_full(almost_full),
`ifdef SYNC_FIFO_ERR_EN
    .err_clr(err_clr), .overflow(overflow), .underflow(underflow),
`endif
    .level(level)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic wr, logic [15:0] wd, logic rd, logic [15:0] d2, logic v,
                              int lvl, logic ovf, logic udf);
    mk = '{wr, wd, rd, d2, v, lvl, ovf, udf};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_lvl(input string tag, input int lvl);
    chk({tag, " level"}, 32'(level), 32'(lvl));
    chk({tag, " empty"}, 32'(buffer_empty), 32'(lvl == 0));
    chk({tag, " full"},  32'(buffer_full),  32'(lvl == 8));
    chk({tag, " ae"},    32'(almost_empty), 32'(lvl <= 2));
    chk({tag, " af"},    32'(almost_full),  32'(lvl >= 6));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; data_1_en = 1'b0; data_1 = '0; data_2_rd = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
    err_clr = 1'b0;
`endif
    for (int i = 0; i < 8; i++) tv[i] = mk(1'b1, 16'(i + 1), 1'b0, 16'h0, 1'b0, i + 1, 1'b0, 1'b0);
    tv[8]  = mk(1'b1, 16'h0009, 1'b0, 16'h0000, 1'b0, 8, 1'b1, 1'b0);
    tv[9]  = mk(1'b1, 16'hAAAA, 1'b1, 16'h0001, 1'b1, 8, 1'b1, 1'b0);
    for (int k = 1; k < 8; k++) tv[9 + k] = mk(1'b0, 16'h0, 1'b1, 16'(k + 1), 1'b1, 8 - k, 1'b1, 1'b0);
    tv[17] = mk(1'b0, 16'h0000, 1'b1, 16'hAAAA, 1'b1, 0, 1'b1, 1'b0);
    tv[18] = mk(1'b0, 16'h0000, 1'b1, 16'hAAAA, 1'b0, 0, 1'b1, 1'b1);
    tv[19] = mk(1'b1, 16'h1234, 1'b1, 16'hAAAA, 1'b0, 1, 1'b1, 1'b1);
    tv[20] = mk(1'b0, 16'h0000, 1'b0, 16'hAAAA, 1'b0, 1, 1'b1, 1'b1);
    tv[21] = mk(1'b0, 16'h0000, 1'b1, 16'h1234, 1'b1, 0, 1'b1, 1'b1);

    #2;
    chk_lvl("reset", 0);
    chk("reset data_2", 32'(data_2), 32'h0);
    chk("reset valid", 32'(data_2_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      data_1_en = tv[i].wr;
      data_1    = tv[i].wd;
      data_2_rd = tv[i].rd;
      tick();
      chk_lvl($sformatf("vec%0d", i), tv[i].lvl);
      chk($sformatf("vec%0d data_2", i), 32'(data_2), 32'(tv[i].d2));
      chk($sformatf("vec%0d valid", i), 32'(data_2_valid), 32'(tv[i].v));
`ifdef SYNC_FIFO_ERR_EN
      chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(tv[i].ovf));
      chk($sformatf("vec%0d underflow", i), 32'(underflow), 32'(tv[i].udf));
`endif
    end
    data_1_en = 1'b0;
    data_2_rd = 1'b0;

`ifdef SYNC_FIFO_ERR_EN
    err_clr = 1'b1;
    tick();
    chk("clr overflow", 32'(overflow), 32'h0);
    chk("clr underflow", 32'(underflow), 32'h0);
    data_2_rd = 1'b1;
    tick();
    chk("set-beats-clr underflow", 32'(underflow), 32'h1);
    chk("set-beats-clr valid", 32'(data_2_valid), 32'h0);
    data_2_rd = 1'b0;
    tick();
    chk("clr again underflow", 32'(underflow), 32'h0);
    err_clr = 1'b0;
`endif

    for (int i = 0; i < 3; i++) begin
      data_1_en = 1'b1;
      data_1    = 16'h0300 + 16'(i);
      q.push_back(data_1);
      tick();
    end
    chk_lvl("preload", 3);
    data_2_rd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_1 = 16'h0400 + 16'(i);
      tick();
      exp_d = q.pop_front();
      q.push_back(16'h0400 + 16'(i));
      chk($sformatf("wrap%0d data_2", i), 32'(data_2), 32'(exp_d));
      chk($sformatf("wrap%0d valid", i), 32'(data_2_valid), 32'h1);
      chk($sformatf("wrap%0d level", i), 32'(level), 32'd3);
    end
    data_1_en = 1'b0;
    data_2_rd = 1'b0;

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_lvl("async rst", 0);
    chk("async rst data_2", 32'(data_2), 32'h0);
    chk("async rst valid", 32'(data_2_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    data_2_rd = 1'b1;
    tick();
    chk("post-rst read valid", 32'(data_2_valid), 32'h0);
    chk("post-rst read data_2", 32'(data_2), 32'h0);
    chk_lvl("post-rst", 0);
    data_2_rd = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
